rs232_avm_slave: RTL and testbench



---
 rtl/rs232_avm_slave.sv | 206 ++++++++++++++++++++
 tb/tb_rs232_avm_slave.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_avm_slave.sv
`default_nettype none
// ============================================================================
// rs232_avm_slave : Avalon-MM UART peripheral (8N1), RX/TX/STATUS registers
// Revision 1.0 - initial release
// ============================================================================
module rs232_avm_slave #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    output logic [31:0] avm_readdata,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic        avm_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic        ack_r;
    logic        req, rd_done, wr_done;
    logic        rx_pop, status_rd, tx_load;
    logic        unused_bits;

    logic        rxd_meta, rxd_sync;
    state_t      rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift, rx_data;
    logic        rx_valid, overrun, frame_err;

    state_t      tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_ready;

    // Every access stalls exactly one cycle and completes while ack_r is high.
    assign req             = avm_read | avm_write;
    assign avm_waitrequest = req & ~ack_r;
    assign rd_done         = req & ack_r & avm_read;
    assign wr_done         = req & ack_r & avm_write & ~avm_read;
    assign rx_pop          = rd_done & (avm_address == 5'd0);
    assign status_rd       = rd_done & (avm_address == 5'd8);
    assign tx_load         = wr_done & (avm_address == 5'd4) & tx_ready;
    assign unused_bits     = ^avm_writedata[31:8];

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) ack_r <= 1'b0;
        else         ack_r <= req & ~ack_r;
    end

    always_comb begin
        avm_readdata = 32'd0;
        if (rd_done) begin
            case (avm_address)
                5'd0:    avm_readdata = {24'd0, rx_data};
                5'd8:    avm_readdata = {22'd0, frame_err, overrun, rx_valid, tx_ready, 6'd0};
                default: avm_readdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // Clears from bus reads come first so a same-cycle receive event wins.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rx_state  <= IDLE;
            rx_cnt    <= 16'd0;
            rx_bit    <= 3'd0;
            rx_shift  <= 8'd0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_pop) rx_valid <= 1'b0;
            if (status_rd) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            case (rx_state)
                IDLE: begin
                    rx_cnt <= 16'd0;
                    rx_bit <= 3'd0;
                    if (!rxd_sync) rx_state <= START;
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= rxd_sync ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_shift <= {rxd_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= IDLE;
                        if (rxd_sync) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_pop) overrun <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            tx_state <= IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            tx_ready <= 1'b1;
            uart_txd <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    tx_cnt   <= 16'd0;
                    if (tx_load) begin
                        tx_shift <= avm_writedata[7:0];
                        tx_ready <= 1'b0;
                        uart_txd <= 1'b0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= 16'd0;
                        tx_bit   <= 3'd0;
                        uart_txd <= tx_shift[0];
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= 16'd0;
                        if (tx_bit == 3'd7) begin
                            uart_txd <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            uart_txd <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= 16'd0;
                        tx_ready <= 1'b1;
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs232_avm_slave.sv
`default_nettype none
// ============================================================================
// tb_rs232_avm_slave : directed scoreboard bench for rs232_avm_slave
// Revision 1.0 - initial release
// ============================================================================
module tb_rs232_avm_slave;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  address;
    logic        read, write;
    logic [31:0] readdata, writedata;
    logic        waitrequest;
    logic        rxd;
    logic        txd;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] d;
    int          w;

    always #5 clk = ~clk;

    rs232_avm_slave #(.CLKS_PER_BIT(CPB)) dut (
        .avm_clk        (clk),
        .avm_rst        (rst),
        .avm_address    (address),
        .avm_read       (read),
        .avm_readdata   (readdata),
        .avm_write      (write),
        .avm_writedata  (writedata),
        .avm_waitrequest(waitrequest),
        .uart_rxd       (rxd),
        .uart_txd       (txd)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        check_val(tag, obs, exp);
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] data, output int waits);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        waits   = 0;
        #1;
        while (waitrequest && waits < 16) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check_val("rd_timeout", {31'd0, waitrequest}, 32'd0);
        data = readdata;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] data, output int waits);
        @(negedge clk);
        address   = a;
        writedata = data;
        write     = 1'b1;
        waits     = 0;
        #1;
        while (waitrequest && waits < 16) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check_val("wr_timeout", {31'd0, waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    // Called right after the loading write completes; checks txd every cycle.
    task automatic mon_tx(input logic [7:0] b, input int n);
        int   slot;
        logic e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            slot = k / CPB;
            if (slot == 0)      e = 1'b0;
            else if (slot <= 8) e = b[slot-1];
            else                e = 1'b1;
            check_val($sformatf("txd[%0d]", k), {31'd0, txd}, {31'd0, e});
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic v;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      v = 1'b0;
            else if (k == 9) v = stop;
            else             v = b[k-1];
            rxd = v;
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; address = 5'd0; read = 1'b0; write = 1'b0;
        writedata = 32'd0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_val("rst_txd", {31'd0, txd}, 32'd1);
        check_val("rst_waitreq", {31'd0, waitrequest}, 32'd0);
        check_val("rst_readdata", readdata, 32'd0);
        exp_q.push_back(32'h40);
        bus_read(5'd8, d, w);
        check_sb("rst_status", d);
        check_val("rst_wait_cycles", w, 32'd1);

        // TX 0xA5 frame, with a status read landing just before the frame ends
        bus_write(5'd4, 32'hA5, w);
        fork
            mon_tx(8'hA5, 10 * CPB);
            begin
                logic [31:0] sd;
                int          sw;
                repeat (37) @(negedge clk);
                bus_read(5'd8, sd, sw);
                check_val("status_busy", sd, 32'h00);
            end
        join
        exp_q.push_back(32'h40);
        bus_read(5'd8, d, w);
        check_sb("status_after_tx", d);

        exp_q.push_back(32'h0);
        bus_read(5'd4, d, w);
        check_sb("read_addr4", d);
        exp_q.push_back(32'h0);
        bus_read(5'd12, d, w);
        check_sb("read_addr12", d);
        bus_write(5'd8, 32'hFFFF_FFFF, w);
        exp_q.push_back(32'h40);
        bus_read(5'd8, d, w);
        check_sb("status_after_bad_wr", d);

        // RX 0x3C, status read while a TX frame keeps tx_ready low
        send_rx(8'h3C, 1'b1);
        bus_write(5'd4, 32'h55, w);
        exp_q.push_back(32'h80);
        bus_read(5'd8, d, w);
        check_sb("status_rx_valid", d);
        exp_q.push_back(32'h3C);
        bus_read(5'd0, d, w);
        check_sb("rx_data_3c", d);
        repeat (45) @(negedge clk);
        exp_q.push_back(32'h40);
        bus_read(5'd8, d, w);
        check_sb("status_after_pop", d);

        // Overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        exp_q.push_back(32'h1C0);
        bus_read(5'd8, d, w);
        check_sb("status_overrun", d);
        exp_q.push_back(32'h22);
        bus_read(5'd0, d, w);
        check_sb("rx_data_22", d);
        exp_q.push_back(32'h40);
        bus_read(5'd8, d, w);
        check_sb("status_overrun_clr", d);

        // Framing error
        send_rx(8'h5A, 1'b0);
        exp_q.push_back(32'h240);
        bus_read(5'd8, d, w);
        check_sb("status_frame_err", d);
        exp_q.push_back(32'h40);
        bus_read(5'd8, d, w);
        check_sb("status_frame_clr", d);

        // Write while busy is dropped; a one-cycle start glitch is rejected
        bus_write(5'd4, 32'hF0, w);
        fork
            mon_tx(8'hF0, 20 * CPB);
            begin
                int bw;
                repeat (5) @(negedge clk);
                bus_write(5'd4, 32'h0F, bw);
                check_val("busy_wr_wait", bw, 32'd1);
                repeat (3) @(negedge clk);
                rxd = 1'b0;
                @(negedge clk);
                rxd = 1'b1;
            end
        join
        exp_q.push_back(32'h40);
        bus_read(5'd8, d, w);
        check_sb("status_after_glitch", d);

        // Reset in the middle of a frame
        bus_write(5'd4, 32'h00, w);
        repeat (6) @(negedge clk);
        check_val("midframe_txd", {31'd0, txd}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_txd", {31'd0, txd}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'h40);
        bus_read(5'd8, d, w);
        check_sb("status_after_rst", d);
        repeat (2 * CPB) @(negedge clk);
        check_val("idle_txd_after_rst", {31'd0, txd}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
